// File: rtl/combo_lock_pkg.sv
// Shared types and helpers for the combination-lock controller.
// Holds the FSM state encoding and code-digit extraction.
package combo_lock_pkg;

   typedef enum logic [1:0] {
      ENTRY   = 2'd0,
      OPEN    = 2'd1,
      LOCKOUT = 2'd2
   } state_t;

   localparam int unsigned DIGITS = 4;

   // Digit idx of a packed code; index 0 is the most-significant (first entered) digit.
   function automatic logic [7:0] code_digit(input logic [31:0] code,
                                             input int unsigned dw,
                                             input int unsigned idx);
      logic [31:0] shifted;
      logic [31:0] mask;
      shifted = code >> (dw * (DIGITS - 1 - idx));
      mask    = (32'd1 << dw) - 32'd1;
      return 8'(shifted & mask);
   endfunction

endpackage

// File: rtl/combo_lock_ctrl_entry_counter.sv
// Entry position counter: 0..4, saturating, clear has priority over increment.
// 'last' flags the position of the final code digit.
module entry_counter
   import combo_lock_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       inc,
   input  logic       clr,
   output logic [2:0] count,
   output logic       last
);

   logic [2:0] count_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         count_reg <= 3'd0;
      end else if (clr) begin
         count_reg <= 3'd0;
      end else if (inc && count_reg != 3'(DIGITS)) begin
         count_reg <= count_reg + 3'd1;
      end
   end

   assign count = count_reg;
   assign last  = (count_reg == 3'(DIGITS - 1));

endmodule

// File: rtl/combo_lock_ctrl.sv
// Combination-lock sequencer: tracks digit entry, compares against CODE,
// and drives unlock / error / lockout status with a shared hold timer.
module combo_lock_ctrl
   import combo_lock_pkg::*;
#(
   parameter int unsigned          DIGIT_W        = 4,
   parameter logic [4*DIGIT_W-1:0] CODE           = 16'h1234,
   parameter int unsigned          MAX_FAILS      = 3,
   parameter int unsigned          UNLOCK_CYCLES  = 500,
   parameter int unsigned          LOCKOUT_CYCLES = 1000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               trig,
   input  logic [DIGIT_W-1:0] digit,
   input  logic               relock,
   output logic [2:0]         count,
   output logic               unlocked,
   output logic               err,
   output logic               locked_out,
   output logic [1:0]         fails
);

   localparam int unsigned TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
   localparam int unsigned TW   = $clog2(TMAX + 1);

   state_t          state_reg, state_next;
   logic            miss_reg, miss_next;
   logic [1:0]      fails_reg, fails_next;
   logic [TW-1:0]   timer_reg, timer_next;
   logic            err_reg, err_next;
   logic            unlocked_reg, locked_out_reg;
   logic            cnt_inc, cnt_clr, cnt_last;
   logic [2:0]      cnt_value;
   logic [DIGIT_W-1:0] expected_digit;
   logic            mismatch;
   logic [1:0]      fails_inc;

   entry_counter u_entry_counter (
      .clk   (clk),
      .rst   (rst),
      .inc   (cnt_inc),
      .clr   (cnt_clr),
      .count (cnt_value),
      .last  (cnt_last)
   );

   // count never reaches 4 while in ENTRY, so the low two bits select the digit.
   assign expected_digit = DIGIT_W'(code_digit(32'(CODE), DIGIT_W, 32'(cnt_value[1:0])));
   assign mismatch       = (digit != expected_digit);
   assign fails_inc      = fails_reg + 2'd1;

   always_comb begin
      state_next = state_reg;
      miss_next  = miss_reg;
      fails_next = fails_reg;
      timer_next = timer_reg + TW'(1);
      err_next   = 1'b0;
      cnt_inc    = 1'b0;
      cnt_clr    = 1'b0;

      case (state_reg)
         ENTRY: begin
            timer_next = '0;
            if (relock) begin
               cnt_clr   = 1'b1;
               miss_next = 1'b0;
            end else if (trig) begin
               if (cnt_last) begin
                  cnt_clr   = 1'b1;
                  miss_next = 1'b0;
                  if (!(miss_reg || mismatch)) begin
                     state_next = OPEN;
                     fails_next = 2'd0;
                  end else begin
                     err_next   = 1'b1;
                     fails_next = fails_inc;
                     if (fails_inc == 2'(MAX_FAILS)) begin
                        state_next = LOCKOUT;
                     end
                  end
               end else begin
                  cnt_inc   = 1'b1;
                  miss_next = miss_reg || mismatch;
               end
            end
         end
         OPEN: begin
            if (relock || timer_reg == TW'(UNLOCK_CYCLES - 1)) begin
               state_next = ENTRY;
            end
         end
         LOCKOUT: begin
            if (timer_reg == TW'(LOCKOUT_CYCLES - 1)) begin
               state_next = ENTRY;
               fails_next = 2'd0;
            end
         end
         default: state_next = ENTRY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= ENTRY;
         miss_reg       <= 1'b0;
         fails_reg      <= 2'd0;
         timer_reg      <= '0;
         err_reg        <= 1'b0;
         unlocked_reg   <= 1'b0;
         locked_out_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         miss_reg       <= miss_next;
         fails_reg      <= fails_next;
         timer_reg      <= timer_next;
         err_reg        <= err_next;
         unlocked_reg   <= (state_next == OPEN);
         locked_out_reg <= (state_next == LOCKOUT);
      end
   end

   assign count      = cnt_value;
   assign unlocked   = unlocked_reg;
   assign err        = err_reg;
   assign locked_out = locked_out_reg;
   assign fails      = fails_reg;

endmodule

// File: tb/tb_combo_lock_ctrl.sv
// Directed bench for combo_lock_ctrl with short timers (8 open / 16 lockout).
// Inputs change on the falling edge; outputs are observed on the falling edge.
module tb_combo_lock_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       trig = 1'b0;
   logic [3:0] digit = 4'd0;
   logic       relock = 1'b0;
   logic [2:0] count;
   logic       unlocked, err, locked_out;
   logic [1:0] fails;

   int tests_run = 0;
   int tests_failed = 0;

   combo_lock_ctrl #(
      .DIGIT_W(4), .CODE(16'h1234), .MAX_FAILS(3),
      .UNLOCK_CYCLES(8), .LOCKOUT_CYCLES(16)
   ) dut (
      .clk(clk), .rst(rst), .trig(trig), .digit(digit), .relock(relock),
      .count(count), .unlocked(unlocked), .err(err),
      .locked_out(locked_out), .fails(fails)
   );

   always #5 clk = ~clk;

   // Packed view of all outputs: {count, unlocked, err, locked_out, fails}
   function automatic logic [7:0] outs();
      return {count, unlocked, err, locked_out, fails};
   endfunction

   task automatic strobe(input logic [3:0] d);
      @(negedge clk);
      trig = 1'b1;
      digit = d;
      @(negedge clk);
      trig = 1'b0;
      $display("[TB] trig digit=%h -> count=%0d unlocked=%0b err=%0b locked_out=%0b fails=%0d",
               d, count, unlocked, err, locked_out, fails);
   endtask

   task automatic relock_pulse();
      @(negedge clk);
      relock = 1'b1;
      @(negedge clk);
      relock = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      tests_run++;
      if (outs() !== 8'b000_0_0_0_00) begin
         tests_failed++;
         $display("FAIL reset_outputs got=%b want=%b", outs(), 8'b000_0_0_0_00);
      end
      rst = 1'b0;
   endtask

   task automatic test_unlock();
      int open_cycles;
      logic [3:0] seq [4] = '{4'h1, 4'h2, 4'h3, 4'h4};
      for (int i = 0; i < 3; i++) begin
         strobe(seq[i]);
         tests_run++;
         if (count !== 3'(i + 1)) begin
            tests_failed++;
            $display("FAIL unlock_count[%0d] got=%0d want=%0d", i, count, i + 1);
         end
      end
      strobe(seq[3]);
      tests_run++;
      if (outs() !== 8'b000_1_0_0_00) begin
         tests_failed++;
         $display("FAIL unlock_first got=%b want=%b", outs(), 8'b000_1_0_0_00);
      end
      open_cycles = 1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         tests_run++;
         if (err !== 1'b0 || count !== 3'd0) begin
            tests_failed++;
            $display("FAIL unlock_hold err=%0b count=%0d want err=0 count=0", err, count);
         end
         if (unlocked) open_cycles++;
         else break;
      end
      tests_run++;
      if (open_cycles !== 8) begin
         tests_failed++;
         $display("FAIL unlock_duration got=%0d want=8", open_cycles);
      end
   endtask

   task automatic test_wrong_then_right();
      strobe(4'h1); strobe(4'h2); strobe(4'h3); strobe(4'h5);
      tests_run++;
      if (outs() !== 8'b000_0_1_0_01) begin
         tests_failed++;
         $display("FAIL wrong_err got=%b want=%b", outs(), 8'b000_0_1_0_01);
      end
      @(negedge clk);
      tests_run++;
      if (err !== 1'b0) begin
         tests_failed++;
         $display("FAIL err_one_cycle got=%0b want=0", err);
      end
      strobe(4'h1); strobe(4'h2); strobe(4'h3); strobe(4'h4);
      tests_run++;
      if (outs() !== 8'b000_1_0_0_00) begin
         tests_failed++;
         $display("FAIL right_after_wrong got=%b want=%b", outs(), 8'b000_1_0_0_00);
      end
      relock_pulse();
      tests_run++;
      if (unlocked !== 1'b0) begin
         tests_failed++;
         $display("FAIL relock_exit got=%0b want=0", unlocked);
      end
   endtask

   task automatic test_lockout();
      int lo_cycles;
      for (int a = 1; a <= 3; a++) begin
         strobe(4'h9); strobe(4'h9); strobe(4'h9); strobe(4'h9);
         tests_run++;
         if (err !== 1'b1 || fails !== 2'(a) || locked_out !== (a == 3)) begin
            tests_failed++;
            $display("FAIL attempt%0d err=%0b fails=%0d locked_out=%0b want err=1 fails=%0d locked_out=%0b",
                     a, err, fails, locked_out, a, (a == 3));
         end
      end
      lo_cycles = 1;
      for (int k = 0; k < 40; k++) begin
         trig  = (k < 8) && (k % 2 == 0);
         digit = 4'(k / 2 + 1);
         @(negedge clk);
         tests_run++;
         if (count !== 3'd0 || unlocked !== 1'b0) begin
            tests_failed++;
            $display("FAIL lockout_ignore count=%0d unlocked=%0b want 0 0", count, unlocked);
         end
         if (locked_out) begin
            lo_cycles++;
            tests_run++;
            if (fails !== 2'd3) begin
               tests_failed++;
               $display("FAIL lockout_fails got=%0d want=3", fails);
            end
         end else begin
            tests_run++;
            if (fails !== 2'd0) begin
               tests_failed++;
               $display("FAIL lockout_end_fails got=%0d want=0", fails);
            end
            break;
         end
      end
      trig = 1'b0;
      tests_run++;
      if (lo_cycles !== 16) begin
         tests_failed++;
         $display("FAIL lockout_duration got=%0d want=16", lo_cycles);
      end
   endtask

   task automatic test_relock_open();
      strobe(4'h1); strobe(4'h2); strobe(4'h3); strobe(4'h4);
      repeat (2) @(negedge clk);
      tests_run++;
      if (unlocked !== 1'b1) begin
         tests_failed++;
         $display("FAIL open_before_relock got=%0b want=1", unlocked);
      end
      relock = 1'b1;
      @(negedge clk);
      relock = 1'b0;
      tests_run++;
      if (unlocked !== 1'b0) begin
         tests_failed++;
         $display("FAIL relock_open got=%0b want=0", unlocked);
      end
      strobe(4'h1);
      tests_run++;
      if (count !== 3'd1) begin
         tests_failed++;
         $display("FAIL entry_after_relock got=%0d want=1", count);
      end
      relock_pulse();
   endtask

   task automatic test_relock_coincident();
      strobe(4'h9); strobe(4'h2);
      @(negedge clk);
      trig = 1'b1; digit = 4'h3; relock = 1'b1;
      @(negedge clk);
      trig = 1'b0; relock = 1'b0;
      tests_run++;
      if (count !== 3'd0) begin
         tests_failed++;
         $display("FAIL relock_with_trig count=%0d want=0", count);
      end
      strobe(4'h1); strobe(4'h2); strobe(4'h3); strobe(4'h4);
      tests_run++;
      if (outs() !== 8'b000_1_0_0_00) begin
         tests_failed++;
         $display("FAIL unlock_after_abandon got=%b want=%b", outs(), 8'b000_1_0_0_00);
      end
      relock_pulse();
   endtask

   task automatic test_reset_mid();
      strobe(4'h9); strobe(4'h9); strobe(4'h9); strobe(4'h9);
      strobe(4'h1); strobe(4'h2);
      tests_run++;
      if (count !== 3'd2 || fails !== 2'd1) begin
         tests_failed++;
         $display("FAIL pre_reset count=%0d fails=%0d want 2 1", count, fails);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      tests_run++;
      if (outs() !== 8'b000_0_0_0_00) begin
         tests_failed++;
         $display("FAIL reset_mid_entry got=%b want=%b", outs(), 8'b000_0_0_0_00);
      end
      for (int a = 0; a < 3; a++) begin
         strobe(4'h9); strobe(4'h9); strobe(4'h9); strobe(4'h9);
      end
      repeat (3) @(negedge clk);
      tests_run++;
      if (locked_out !== 1'b1 || fails !== 2'd3) begin
         tests_failed++;
         $display("FAIL pre_reset_lockout locked_out=%0b fails=%0d want 1 3", locked_out, fails);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      tests_run++;
      if (outs() !== 8'b000_0_0_0_00) begin
         tests_failed++;
         $display("FAIL reset_mid_lockout got=%b want=%b", outs(), 8'b000_0_0_0_00);
      end
      strobe(4'h1); strobe(4'h2); strobe(4'h3); strobe(4'h4);
      tests_run++;
      if (outs() !== 8'b000_1_0_0_00) begin
         tests_failed++;
         $display("FAIL unlock_after_reset got=%b want=%b", outs(), 8'b000_1_0_0_00);
      end
   endtask

   initial begin
      test_reset();
      test_unlock();
      test_wrong_then_right();
      test_lockout();
      test_relock_open();
      test_relock_coincident();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
